// File: rtl/bpsk_modulator.sv
// BPSK modulator: one data bit per symbol, held for SPS samples and mapped
// to +/- a continuous-phase NCO cosine carrier (bit 0 -> +, bit 1 -> -).
module bpsk_modulator #(
    parameter int unsigned SPS   = 16,
    parameter int unsigned OUT_W = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [31:0]             fcw,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    sym_start,
    output logic                    idle
);

    localparam int unsigned CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);
    localparam real PI = 3.14159265358979323846;

    typedef logic [255:0][OUT_W-1:0] lut_t;

    // Cosine table scaled to a symmetric peak so negation cannot overflow.
    function automatic lut_t build_lut();
        lut_t   t;
        real    amp;
        real    v;
        longint q;
        t   = '0;
        amp = real'((64'd1 << (OUT_W - 1)) - 64'd1);
        for (int unsigned a = 0; a < 256; a++) begin
            v = $cos(2.0 * PI * real'(a) / 256.0) * amp;
            if (v >= 0.0) q = longint'($rtoi(v + 0.5));
            else          q = -longint'($rtoi(-v + 0.5));
            t[a[7:0]] = q[OUT_W-1:0];
        end
        return t;
    endfunction

    localparam lut_t LUT = build_lut();

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_bit;
    logic [31:0]             r_phase;
    logic signed [OUT_W-1:0] r_s1_lut;
    logic                    r_s1_act;
    logic                    r_s1_bit;
    logic                    r_s1_start;
    logic signed [OUT_W-1:0] r_dout;
    logic                    r_dout_valid;
    logic                    r_sym_start;

    logic w_last;
    logic w_hs;

    assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);
    // Ready is gated by reset so it reads 0 for the whole reset interval.
    assign bit_ready = sys_rst_n && ((r_state == S_IDLE) || w_last);
    assign w_hs      = bit_valid && bit_ready;

    // Free-running phase accumulator; only reset clears it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_phase <= '0;
        else            r_phase <= r_phase + fcw;
    end

    // Symbol FSM: accept a bit, hold it for SPS cycles, chain or fall idle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_bit   <= bit_in;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        if (w_hs) r_bit   <= bit_in;
                        else      r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Stage 1: carrier lookup plus matching symbol bit and start flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1_lut   <= '0;
            r_s1_act   <= 1'b0;
            r_s1_bit   <= 1'b0;
            r_s1_start <= 1'b0;
        end else begin
            r_s1_lut   <= LUT[r_phase[31:24]];
            r_s1_act   <= (r_state == S_RUN);
            r_s1_bit   <= r_bit;
            r_s1_start <= (r_state == S_RUN) && (r_cnt == '0);
        end
    end

    // Stage 2: apply bit polarity and blank samples outside symbols.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_sym_start  <= 1'b0;
        end else begin
            if (!r_s1_act)     r_dout <= '0;
            else if (r_s1_bit) r_dout <= -r_s1_lut;
            else               r_dout <= r_s1_lut;
            r_dout_valid <= r_s1_act;
            r_sym_start  <= r_s1_start;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign sym_start  = r_sym_start;
    assign idle       = (r_state == S_IDLE) && !r_s1_act && !r_dout_valid;

endmodule
